// File: rtl/jk_ff_pkg.sv
// -----------------------------------------------------------------------------
// jk_ff_pkg
//   Shared definitions for the JK flip-flop family.
//   - jk_action_e : the four JK actions (hold, clear, set, toggle).
//   - jk_decode() : maps a {J,K} pair to its action.
//   - jk_next()   : pure next-state function of {J,K,Qcur}.
// -----------------------------------------------------------------------------
package jk_ff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_action_e;

  function automatic jk_action_e jk_decode(input logic j, input logic k);
    return jk_action_e'({j, k});
  endfunction

  // Characteristic equation Qn = J&~Q | ~K&Q. Written as plain logic rather
  // than a case on the action, so an X/Z on J or K propagates to Q instead of
  // silently falling into a default branch.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
//   One JK bit-slice: a single rising-edge flop with synchronous active-low
//   reset.
//   Parameters:
//     INIT_VAL  power-up value of the flop (tie to the same bit as rst_val)
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   synchronous reset, active low
//     j        in   set request
//     k        in   clear request
//     rst_val  in   value loaded while rst_n is low
//     q        out  registered state
// -----------------------------------------------------------------------------
module jk_cell
  import jk_ff_pkg::*;
#(
  parameter logic INIT_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  // Declaration initialiser gives the power-up value, so the slice behaves
  // correctly even if reset is never asserted.
  logic r_q = INIT_VAL;

  // NOTE: reset is sampled inside the clocked block (synchronous), and the
  // state update uses <= so every slice sees pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= rst_val;
    end else begin
      r_q <= jk_next(j, k, r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_ff.sv
// -----------------------------------------------------------------------------
// jk_ff
//   Vector of WIDTH independent clocked JK flip-flops with complementary
//   outputs. Each bit holds/clears/sets/toggles on the rising clock edge
//   according to its own J/K pair.
//   Parameters:
//     WIDTH      number of bit-slices (default 1)
//     RESET_VAL  reset and power-up value of Q (default all zeros)
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   synchronous reset, active low (overrides J/K)
//     J      in   per-bit set request
//     K      in   per-bit clear request
//     Q      out  registered state
//     Qbar   out  ~Q, derived from the same register (no second flop)
// -----------------------------------------------------------------------------
module jk_ff
  import jk_ff_pkg::*;
#(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  logic [WIDTH-1:0] w_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell #(
      .INIT_VAL (RESET_VAL[gi])
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .j       (J[gi]),
      .k       (K[gi]),
      .rst_val (RESET_VAL[gi]),
      .q       (w_q[gi])
    );
  end

  // Both outputs come from the one register so they never disagree by more
  // than an inverter delay.
  assign Q    = w_q;
  assign Qbar = ~w_q;

endmodule

// File: tb/tb_jk_ff.sv
// -----------------------------------------------------------------------------
// tb_jk_ff
//   Self-checking bench for jk_ff. Two instances: a default 1-bit slice and a
//   4-bit slice with RESET_VAL = 4'b1010. A behavioural model of the JK truth
//   table tracks the expected Q of each instance.
// -----------------------------------------------------------------------------
module tb_jk_ff;
  import jk_ff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n1, rst_n4;
  logic [0:0] j1, k1;
  logic [3:0] j4, k4;
  logic [0:0] q1, qb1;
  logic [3:0] q4, qb4;

  logic [0:0] ref_q1;
  logic [3:0] ref_q4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] RV4 = 4'b1010;

  always #10 clk = ~clk;

  jk_ff u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .J     (j1),
    .K     (k1),
    .Q     (q1),
    .Qbar  (qb1)
  );

  jk_ff #(
    .WIDTH     (4),
    .RESET_VAL (4'b1010)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n4),
    .J     (j4),
    .K     (k4),
    .Q     (q4),
    .Qbar  (qb4)
  );

  // Truth-table model: reset wins, otherwise each bit independently follows
  // hold / clear / set / toggle.
  function automatic logic [3:0] model_next(input logic [3:0] j, input logic [3:0] k,
                                            input logic [3:0] q, input logic rst,
                                            input logic [3:0] rv);
    logic [3:0] n;
    if (!rst) return rv;
    n = q;
    for (int i = 0; i < 4; i++) begin
      if (j[i] && k[i])      n[i] = ~q[i];
      else if (j[i])         n[i] = 1'b1;
      else if (k[i])         n[i] = 1'b0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q1"},  {3'b000, q1},  {3'b000, ref_q1});
    check({tag, "_qb1"}, {3'b000, qb1}, {3'b000, ~ref_q1});
    check({tag, "_q4"},  q4,  ref_q4);
    check({tag, "_qb4"}, qb4, ~ref_q4);
  endtask

  // One clock edge: model follows the values present at the edge, outputs are
  // sampled 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    ref_q1 = model_next({3'b000, j1}, {3'b000, k1}, {3'b000, ref_q1}, rst_n1, 4'b0000) & 4'b0001;
    ref_q4 = model_next(j4, k4, ref_q4, rst_n4, RV4);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n1 = 1'b1; rst_n4 = 1'b1;
    j1 = '0; k1 = '0; j4 = '0; k4 = '0;
    ref_q1 = 1'b0;
    ref_q4 = RV4;

    // Power-up without reset: initial value held across 5 edges.
    #1;
    check_all("powerup");
    for (int i = 0; i < 5; i++) tick("hold_pu");
    check("pu_q1_const", {3'b000, q1}, 4'b0000);
    check("pu_q4_const", q4, 4'b1010);

    // Clear then set.
    j1 = 1'b0; k1 = 1'b1;
    tick("clear");
    check("clear_q1_const", {3'b000, q1}, 4'b0000);
    j1 = 1'b1; k1 = 1'b0;
    tick("set");
    check("set_q1_const",  {3'b000, q1},  4'b0001);
    check("set_qb1_const", {3'b000, qb1}, 4'b0000);

    // Toggle for 6 edges from Q=0.
    j1 = 1'b0; k1 = 1'b1;
    tick("clr2");
    j1 = 1'b1; k1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("toggle");
      check("toggle_q1_const", {3'b000, q1}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
    end

    // J/K pulse between edges has no effect: only edge values matter.
    j1 = 1'b0; k1 = 1'b0; j4 = '0; k4 = '0;
    tick("pre_glitch");
    j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
    #5;
    j1 = 1'b0; k1 = 1'b0; j4 = '0; k4 = '0;
    tick("glitch");

    // Free-running pattern from all zeros: K toggles every cycle, J every
    // other cycle.
    j1 = 1'b0; k1 = 1'b1;
    tick("fr_clr");
    j1 = 1'b0; k1 = 1'b0; j4 = '0; k4 = '0;
    for (int i = 0; i < 16; i++) begin
      tick("freerun");
      check("freerun_noX", {3'b000, $isunknown(q1)}, 4'b0000);
      k1 = ~k1; k4 = ~k4;
      if (i % 2 == 1) begin
        j1 = ~j1; j4 = ~j4;
      end
    end

    // Reset overrides set; asserted between edges it waits for the edge.
    j1 = 1'b1; k1 = 1'b0;
    tick("pre_rst_set");
    rst_n1 = 1'b0;
    #5;
    check("rst_between_edges", {3'b000, q1}, 4'b0001);
    tick("rst_edge");
    check("rst_q1_const", {3'b000, q1}, 4'b0000);
    // Release: J/K apply from the edge where rst_n is first sampled high.
    rst_n1 = 1'b1;
    tick("rst_release");
    check("release_q1_const", {3'b000, q1}, 4'b0001);

    // 4-bit: reset to 1010, then J=0011 K=0101:
    // bit0 toggle 0->1, bit1 set ->1, bit2 clear ->0, bit3 hold 1.
    rst_n4 = 1'b0;
    tick("rst4");
    check("rst4_const", q4, 4'b1010);
    rst_n4 = 1'b1; j4 = 4'b0011; k4 = 4'b0101;
    tick("vec4");
    check("vec4_q_const",  q4,  4'b1011);
    check("vec4_qb_const", qb4, 4'b0100);

    // Randomised stimulus with occasional reset on both instances.
    for (int i = 0; i < 200; i++) begin
      j1 = 1'($urandom); k1 = 1'($urandom);
      j4 = 4'($urandom); k4 = 4'($urandom);
      rst_n1 = ($urandom_range(0, 7) != 0);
      rst_n4 = ($urandom_range(0, 7) != 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
